demux1to7_capture: RTL
======================

Name: demux1to7_capture

Overview:
- Sequential 1-to-7 demultiplexer that feeds the 7-to-1 mux path on the DE1-SoC lab boards.
- Routes the single-bit input `in` into one of seven registered output bits, selected either by an explicit address or by an internal auto-incrementing scan counter.
- In scan mode it acts as a 7-bit serial-to-parallel receiver and pulses `frame_done` when the frame is complete.
- Drives LEDR[6:0] from SW/KEY in the board-level wrapper.

Parameters:
- NUM_OUT, 7: number of output bits; valid selects are 0..NUM_OUT-1.
- SEL_W, 3: select/counter width; must satisfy 2**SEL_W > NUM_OUT.
- RESET_VAL, 7'b0000000: value loaded into `out` on reset.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  1  data bit to route.
- load  input  1  write strobe, sampled each rising edge.
- mode  input  1  0 = addressed mode, 1 = scan mode.
- DemuxSelect  input  SEL_W  target index in addressed mode; ignored in scan mode.
- out  output  NUM_OUT  registered, demultiplexed data bits.
- scan_idx  output  SEL_W  current scan counter value (next index to be written).
- frame_done  output  1  one-cycle pulse after index NUM_OUT-1 is captured in scan mode.
- bad_sel  output  1  one-cycle pulse when an addressed write targets an index >= NUM_OUT.

Behaviour:
- Clock and reset: one clock, `clock`; reset is synchronous and active-high on port `reset`. Reset has priority over every other input on the same edge.
- Reset values: out = RESET_VAL, scan_idx = 0, frame_done = 0, bad_sel = 0, FSM = IDLE.
- Latency: any capture appears on `out` one cycle after the edge that samples load = 1. Bits not being written always hold their value.
- Addressed mode (mode = 0), load = 1:
  - If DemuxSelect < NUM_OUT: out[DemuxSelect] <= in.
  - If DemuxSelect = 7: no write; bad_sel = 1 for the following cycle. This mirrors the mux's default branch.
  - The FSM is forced to IDLE and scan_idx to 0 every cycle mode = 0.
- load = 0 in either mode: no write, no state change except the frame_done/bad_sel self-clear.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: on mode = 1 and load = 1, write out[0] <= in, set scan_idx <= 1, go to SHIFT.
  - SHIFT, load = 1, scan_idx < NUM_OUT-1: write out[scan_idx] <= in, increment scan_idx.
  - SHIFT, load = 1, scan_idx = NUM_OUT-1: write out[6], wrap scan_idx <= 0, go to DONE.
  - DONE: frame_done = 1 for exactly this cycle.
    - If load = 1 and mode = 1 this same cycle: start a new frame (write out[0], scan_idx <= 1, go to SHIFT). Back-to-back frames need no idle gap.
    - Otherwise go to IDLE.
- Mode drops to 0 mid-frame: abort to IDLE with scan_idx <= 0. Partially written bits are retained and no frame_done is issued. An addressed write on that same edge is performed normally.
- Reset mid-frame: everything returns to reset values. No frame_done and no bad_sel.
- Outputs frame_done and bad_sel are registered, never combinational, and are never asserted together.

Decomposition:
- Shared package `demux_pkg`:
  - constants NUM_OUT = 7 and SEL_W = 3;
  - FSM state encoding IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  - the mux/demux select constant for the invalid index, 3'b111.
- One natural sub-module, `mod_n_counter`, with ports clock, reset, clear, enable, count[SEL_W-1:0] and wrap pulse. It counts 0..NUM_OUT-1 and wraps to 0. It provides scan_idx and the terminal-count signal used by the FSM.

Test Plan:
- Reset check: assert reset for 2 cycles while load = 1, mode = 1, in = 1 -> out = 7'b0000000, scan_idx = 0, frame_done = 0, bad_sel = 0.
- Addressed writes: mode = 0, in = 1, DemuxSelect = 3 then 6, load = 1 for each -> out = 7'b0001000, then 7'b1001000. An intervening cycle with load = 0 changes nothing.
- Invalid select: mode = 0, DemuxSelect = 3'b111, in = 1, load = 1 -> out unchanged and bad_sel high for exactly 1 cycle.
- Scan frame: mode = 1, 7 consecutive loads with in = 1,0,1,1,0,0,1 (bit 0 first) -> out = 7'b1001101, frame_done high for 1 cycle after the 7th edge, scan_idx = 0.
- Back-to-back frames: load held high for 14 edges with in = 1 -> frame_done pulses exactly twice, 7 cycles apart, with no dropped bit.
- Mid-frame abort: 3 scan loads, then mode = 0 with DemuxSelect = 5, in = 1 -> bits 0..2 retained, out[5] = 1, no frame_done. A following scan frame starts again at index 0.

Source files
------------

// File: rtl/demux1to7_capture_pkg.sv
// demux1to7_capture_pkg: shared sizes, select constants and FSM encoding
package demux_pkg;
  localparam int NUM_OUT = 7;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_OUT - 1);
  localparam logic [SEL_W-1:0] INVALID_SEL = 3'b111;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/demux1to7_capture_if.sv
// demux1to7_capture_if: data, strobe, select and status bundle of the demux
interface demux1to7_capture_if;
  import demux_pkg::*;
  logic in;
  logic load;
  logic mode;
  logic [SEL_W-1:0] DemuxSelect;
  logic [NUM_OUT-1:0] out;
  logic [SEL_W-1:0] scan_idx;
  logic frame_done;
  logic bad_sel;
  modport master (
    output in, load, mode, DemuxSelect,
    input out, scan_idx, frame_done, bad_sel
  );
  modport slave (
    input in, load, mode, DemuxSelect,
    output out, scan_idx, frame_done, bad_sel
  );
endinterface

// File: rtl/demux1to7_capture_mod_n_counter.sv
// mod_n_counter: scan index counting 0..NUM_OUT-1, wrap flags the terminal write
module mod_n_counter
  import demux_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [SEL_W-1:0] count,
  output logic             wrap
);
  assign wrap = enable && count == LAST_SEL;
  always_ff @(posedge clock) begin
    if (reset || clear) count <= '0;
    else if (enable) count <= wrap ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/demux1to7_capture.sv
// demux1to7_capture: addressed or scanned 1-to-7 registered demux with frame/bad-select pulses
module demux1to7_capture
  import demux_pkg::*;
#(
  parameter logic [NUM_OUT-1:0] RESET_VAL = '0
) (
  input logic clock,
  input logic reset,
  demux1to7_capture_if.slave bus
);
  logic [1:0] state, state_nx;
  logic [SEL_W-1:0] wr_idx;
  logic wr_en, scan_ld, wrap;
  assign scan_ld = bus.mode && bus.load;
  mod_n_counter u_cnt (
    .clock(clock),
    .reset(reset),
    .clear(!bus.mode),
    .enable(scan_ld),
    .count(bus.scan_idx),
    .wrap(wrap)
  );
  // scan_idx is always 0 in IDLE and DONE, so it doubles as the frame-start index
  always_comb begin
    state_nx = !bus.mode ? IDLE
             : scan_ld ? ((state == SHIFT && wrap) ? DONE : SHIFT)
             : (state == DONE ? IDLE : state);
    wr_idx = bus.mode ? bus.scan_idx : bus.DemuxSelect;
    wr_en = bus.load && (bus.mode || bus.DemuxSelect <= LAST_SEL);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      bus.out <= RESET_VAL;
      bus.frame_done <= 1'b0;
      bus.bad_sel <= 1'b0;
    end else begin
      state <= state_nx;
      if (wr_en) bus.out[wr_idx] <= bus.in;
      bus.frame_done <= scan_ld && state == SHIFT && wrap;
      bus.bad_sel <= !bus.mode && bus.load && bus.DemuxSelect > LAST_SEL;
    end
  end
endmodule
